// File: rtl/cdm16_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdm16_seq_ctrl
// Description : Sequential 16x16 carry-disregard approximate multiplier. One
//               shared cd9 8x4 tile multiplier is issued once per clock over
//               8 tiles, and the tile results are accumulated exactly.
//               Optional macro CDM_SEQ_OPCNT_EN adds a saturating op_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
// cd9 tile: in partial-product columns 0..8 the carries are disregarded (the
// column bit is the XOR of its terms). Columns 9..11 are summed exactly.
module cdm16_seq_ctrl #(
    parameter int ZERO_SKIP = 1,
    parameter int ACC_W     = 32   // only 32 is supported
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_p,
    output logic             busy
`ifdef CDM_SEQ_OPCNT_EN
    ,
    output logic [15:0]      op_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [2:0]         r_idx_q, w_idx_d;
    logic [15:0]        r_a_q, w_a_d;
    logic [15:0]        r_b_q, w_b_d;
    logic [ACC_W-1:0]   r_acc_q, w_acc_d;
    logic [ACC_W-1:0]   r_out_p_q, w_out_p_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_busy_q, w_busy_d;

    logic [7:0]         w_tile_a;
    logic [15:0]        w_b_shifted;
    logic [3:0]         w_tile_b;
    logic [8:0]         w_cd_lo;
    logic [11:0]        w_cd_hi;
    logic [11:0]        w_cd_r;
    logic [4:0]         w_shift;
    logic [ACC_W-1:0]   w_term;
    logic [ACC_W-1:0]   w_acc_sum;
    logic               w_skip;

    // Tile operand selection: idx[2] picks the A byte, idx[1:0] the B nibble.
    assign w_tile_a    = r_idx_q[2] ? r_a_q[15:8] : r_a_q[7:0];
    assign w_b_shifted = r_b_q >> {r_idx_q[1:0], 2'b00};
    assign w_tile_b    = w_b_shifted[3:0];

    always_comb begin
        w_cd_lo = '0;
        w_cd_hi = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i + j < 9) begin
                    w_cd_lo[i+j] = w_cd_lo[i+j] ^ (w_tile_a[i] & w_tile_b[j]);
                end else begin
                    w_cd_hi = w_cd_hi + (12'(w_tile_a[i] & w_tile_b[j]) << (i + j));
                end
            end
        end
    end

    assign w_cd_r    = w_cd_hi | {3'b000, w_cd_lo};
    assign w_shift   = {1'b0, r_idx_q[2], 3'b000} + {1'b0, r_idx_q[1:0], 2'b00};
    assign w_term    = ACC_W'(w_cd_r) << w_shift;
    assign w_acc_sum = r_acc_q + w_term;
    assign w_skip    = (ZERO_SKIP != 0) && ((in_a == 16'h0000) || (in_b == 16'h0000));

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_acc_d       = r_acc_q;
        w_out_p_d     = r_out_p_q;
        w_out_valid_d = r_out_valid_q;
        w_busy_d      = r_busy_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_a_d    = in_a;
                    w_b_d    = in_b;
                    w_acc_d  = '0;
                    w_idx_d  = 3'd0;
                    w_busy_d = 1'b1;
                    if (w_skip) begin
                        w_state_d     = ST_DONE;
                        w_out_valid_d = 1'b1;
                        w_out_p_d     = '0;
                    end else begin
                        w_state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_acc_d = w_acc_sum;
                w_idx_d = r_idx_q + 3'd1;
                if (r_idx_q == 3'd7) begin
                    w_state_d     = ST_DONE;
                    w_out_valid_d = 1'b1;
                    w_out_p_d     = w_acc_sum;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_d     = ST_IDLE;
                    w_out_valid_d = 1'b0;
                    w_busy_d      = 1'b0;
                end
            end
            default: begin
                w_state_d     = ST_IDLE;
                w_out_valid_d = 1'b0;
                w_busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_IDLE;
            r_idx_q       <= 3'd0;
            r_a_q         <= 16'h0000;
            r_b_q         <= 16'h0000;
            r_acc_q       <= '0;
            r_out_p_q     <= '0;
            r_out_valid_q <= 1'b0;
            r_busy_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_acc_q       <= w_acc_d;
            r_out_p_q     <= w_out_p_d;
            r_out_valid_q <= w_out_valid_d;
            r_busy_q      <= w_busy_d;
        end
    end

    assign in_ready  = (r_state_q == ST_IDLE);
    assign out_valid = r_out_valid_q;
    assign out_p     = r_out_p_q;
    assign busy      = r_busy_q;

`ifdef CDM_SEQ_OPCNT_EN
    logic [15:0] r_op_cnt_q, w_op_cnt_d;
    logic        w_handoff;

    assign w_handoff = r_out_valid_q & out_ready;

    always_comb begin
        w_op_cnt_d = r_op_cnt_q;
        if (w_handoff && (r_op_cnt_q != 16'hFFFF)) begin
            w_op_cnt_d = r_op_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_cnt_q <= 16'h0000;
        end else begin
            r_op_cnt_q <= w_op_cnt_d;
        end
    end

    assign op_cnt = r_op_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/cdm16_seq_ctrl.md
Name: cdm16_seq_ctrl

Overview:
- Sequencer that computes a 16x16 carry-disregard approximate product using one shared cd9 8x4 approximate multiplier instance.
- The multiplication is split into 8 tiles: 2 A bytes x 4 B nibbles.
- One tile is issued per clock. Each tile's 12-bit cd9 result is shifted and accumulated into a 32-bit result.
- Sits between an operand source and result sink with valid/ready handshakes. Area-saving alternative to a fully parallel cdm16 array.

Parameters:
- ZERO_SKIP, 1, when 1 an operand pair with A==0 or B==0 bypasses RUN and completes with product 0.
- ACC_W, 32, accumulator/result width; fixed at 32 for the 16x16 case, and values other than 32 are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_a  input  16  multiplicand A
- in_b  input  16  multiplier B
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_p  output  32  approximate product
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at edge): state=IDLE. out_valid=0, out_p=0, busy=0, in_ready=1 (combinational from IDLE), tile index=0, captured operands=0, accumulator=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a_q=in_a and b_q=in_b, clear acc=0, set idx=0.
  - Next state is RUN, except when ZERO_SKIP=1 and (in_a==0 || in_b==0): then acc=0 and next state is DONE.
- RUN:
  - in_ready=0. idx is a 3-bit counter: i=idx[2] selects the A byte, j=idx[1:0] selects the B nibble.
  - The cd9 instance is driven combinationally with A=a_q[8i+7:8i], B=b_q[4j+3:4j].
  - Each cycle: acc <= acc + (zero-extend(R) << (8i+4j)). Addition is exact and modulo 2^32; approximation exists only inside cd9.
  - idx increments each cycle. After the idx=7 accumulate, next state is DONE.
- DONE:
  - out_valid=1 and out_p=acc, held stable until out_ready=1 at a clock edge.
  - On that edge: out_valid drops and the state returns to IDLE.
  - in_ready=0 in DONE; no accept on the same edge as result handoff.
- Latency: accept edge at cycle 0; out_valid is high from cycle 9 (8 RUN cycles + 1). With the zero-skip path, out_valid is high from cycle 1.
- Throughput: at most one operation per 10 cycles (zero-skip: per 2 cycles) with out_ready held high.
- The busy output is registered alongside the state.
- in_a/in_b are ignored outside the IDLE accept edge. Changes while RUN have no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted, no result is produced, and all state returns to reset values on that edge.
- out_valid never rises without a corresponding accept. out_p is undefined-free: 0 whenever out_valid=0 after reset until the first DONE; otherwise it holds the last acc.

Optional Feature:
- Macro: CDM_SEQ_OPCNT_EN.
- Defined: adds output port op_cnt (16 bits). It increments by 1 on each completed result handoff (out_valid&&out_ready), saturates at 0xFFFF, and resets to 0 on rst. Zero-skipped operations are counted.
- Not defined: no op_cnt port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Reset then in_a=0x0003, in_b=0x0005, out_ready=1 -> in_ready drops after accept; out_valid high at cycle 9; out_p=0x0000000F; in_ready high the cycle after handoff.
- in_a=0x0001, in_b=0x1111 -> out_p=0x00001111 after 8 RUN cycles; idx visits 0..7 once each.
- in_a=0xFFFF, in_b=0x0001 -> out_p=0x0000FFFF. Random operands (1000 pairs) -> out_p matches a golden model applying the cd9 bitwise equations per tile plus exact shifted sum.
- ZERO_SKIP=1, in_a=0x0000, in_b=0xABCD -> out_valid at cycle 1, out_p=0. With ZERO_SKIP=0 the same input -> out_valid at cycle 9, out_p=0.
- out_ready=0 for 5 cycles in DONE -> out_valid and out_p stay stable, in_ready stays 0. Result handed off on the first edge with out_ready=1.
- rst=1 asserted at RUN idx=4 -> next cycle state=IDLE, out_valid=0, busy=0, in_ready=1. The following op (0x0003 x 0x0005) returns 0x0000000F. With CDM_SEQ_OPCNT_EN: op_cnt=1 after it, 0 after rst.
